// File: rtl/hex_display_driver.sv
// Two-digit time-multiplexed 7-segment driver with frame-synchronous value commit.
// Optional: define LEADING_ZERO_BLANK_EN to keep the high digit dark when its nibble is zero.
module hex_display_driver #(
    parameter logic [23:0] REFRESH_DIV  = 24'd50_000,
    parameter logic [7:0]  BLANK_CYCLES = 8'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       flag_in,
    input  logic       load,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [1:0] digit_en,
    output logic       pending,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        BLANK_LO = 2'd0,
        SHOW_LO  = 2'd1,
        BLANK_HI = 2'd2,
        SHOW_HI  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [23:0] cnt_q;
    logic [23:0] limit;
    logic        last;
    logic        commit;

    logic [7:0]  disp;
    logic        disp_flag;
    logic [7:0]  pend_data;
    logic        pend_flag;

    // Segment order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h00;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        limit = {16'd0, BLANK_CYCLES} - 24'd1;
        if (state_q == SHOW_LO || state_q == SHOW_HI) begin
            limit = REFRESH_DIV - 24'd1;
        end
        last   = (cnt_q == limit);
        commit = (state_q == SHOW_HI) && last;
    end

    // State and dwell counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK_LO;
            cnt_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= last ? 24'd0 : cnt_q + 24'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        seg_out    = 7'h00;
        dp_out     = 1'b0;
        digit_en   = 2'b00;
        frame_done = 1'b0;
        case (state_q)
            BLANK_LO: begin
                if (last) state_d = SHOW_LO;
            end
            SHOW_LO: begin
                if (last) state_d = BLANK_HI;
                digit_en = 2'b01;
                seg_out  = seg_decode(disp[3:0]);
                dp_out   = disp_flag;
            end
            BLANK_HI: begin
                if (last) state_d = SHOW_HI;
            end
            SHOW_HI: begin
                if (last) state_d = BLANK_LO;
                frame_done = commit;
`ifdef LEADING_ZERO_BLANK_EN
                if (disp[7:4] != 4'h0) begin
                    digit_en = 2'b10;
                    seg_out  = seg_decode(disp[7:4]);
                end
`else
                digit_en = 2'b10;
                seg_out  = seg_decode(disp[7:4]);
`endif
            end
            default: state_d = BLANK_LO;
        endcase
    end

    // Pending capture and frame-boundary commit; a load on the commit cycle survives into the next frame
    always_ff @(posedge clk) begin
        if (reset) begin
            disp      <= 8'h00;
            disp_flag <= 1'b0;
            pend_data <= 8'h00;
            pend_flag <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (commit && pending) begin
                disp      <= pend_data;
                disp_flag <= pend_flag;
            end
            if (load) begin
                pend_data <= data_in;
                pend_flag <= flag_in;
                pending   <= 1'b1;
            end else if (commit) begin
                pending   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver; a frame-position model feeds a scoreboard each cycle.
module tb_hex_display_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       flag_in = 1'b0;
    logic       load = 1'b0;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [1:0] digit_en;
    logic       pending;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    hex_display_driver #(
        .REFRESH_DIV (24'd4),
        .BLANK_CYCLES(8'd2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .flag_in   (flag_in),
        .load      (load),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .digit_en  (digit_en),
        .pending   (pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] den;
        logic       dp;
        logic       pend;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Frame position 0..11: 0-1 blank, 2-5 low digit, 6-7 blank, 8-11 high digit
    int         pos = 0;
    logic [7:0] m_disp = 8'h00;
    logic       m_flag = 1'b0;
    logic [7:0] m_pd = 8'h00;
    logic       m_pf = 1'b0;
    logic       m_pending = 1'b0;

    function automatic exp_t model_out();
        exp_t e;
        e      = '0;
        e.pend = m_pending;
        e.fd   = (pos == 11);
        if (pos >= 2 && pos <= 5) begin
            e.den = 2'b01;
            e.seg = seg_tbl[m_disp[3:0]];
            e.dp  = m_flag;
        end else if (pos >= 8) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (m_disp[7:4] != 4'h0) begin
                e.den = 2'b10;
                e.seg = seg_tbl[m_disp[7:4]];
            end
`else
            e.den = 2'b10;
            e.seg = seg_tbl[m_disp[7:4]];
`endif
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s pos=%0d observed=%h expected=%h", tag, pos, obs, exp_v);
        end
    endtask

    task automatic tick(input logic rst_v, input logic ld, input logic [7:0] d, input logic f);
        exp_t e;
        logic nxt_pending;
        reset   = rst_v;
        load    = ld;
        data_in = d;
        flag_in = f;
        if (rst_v) begin
            pos = 0; m_disp = 8'h00; m_flag = 1'b0;
            m_pd = 8'h00; m_pf = 1'b0; m_pending = 1'b0;
        end else begin
            nxt_pending = m_pending;
            if (pos == 11 && m_pending) begin
                m_disp = m_pd;
                m_flag = m_pf;
            end
            if (pos == 11) nxt_pending = 1'b0;
            if (ld) begin
                m_pd = d;
                m_pf = f;
                nxt_pending = 1'b1;
            end
            m_pending = nxt_pending;
            pos = (pos + 1) % 12;
        end
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() > 0)
        else begin
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("seg_out",    seg_out,            e.seg);
            chk("digit_en",   {5'd0, digit_en},   {5'd0, e.den});
            chk("dp_out",     {6'd0, dp_out},     {6'd0, e.dp});
            chk("pending",    {6'd0, pending},    {6'd0, e.pend});
            chk("frame_done", {6'd0, frame_done}, {6'd0, e.fd});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 12 && pos != p; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset, then one frame of "00"
        repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0);
        idle(11);
        idle(12);

        // Load 3A with flag mid-frame, shown from the next frame
        run_to(4);
        tick(1'b0, 1'b1, 8'h3A, 1'b1);
        run_to(11);
        idle(12);

        // Two loads in one frame: last wins
        run_to(1);
        tick(1'b0, 1'b1, 8'h12, 1'b0);
        run_to(6);
        tick(1'b0, 1'b1, 8'h34, 1'b0);
        run_to(11);
        idle(12);

        // Pending 56, then load 78 on the commit cycle
        run_to(3);
        tick(1'b0, 1'b1, 8'h56, 1'b0);
        run_to(11);
        tick(1'b0, 1'b1, 8'h78, 1'b0);
        idle(24);

        // Load 05 on a commit cycle with nothing pending
        run_to(11);
        tick(1'b0, 1'b1, 8'h05, 1'b0);
        idle(24);

        // Pending FF, reset during the high digit (load during reset is ignored)
        run_to(2);
        tick(1'b0, 1'b1, 8'hFF, 1'b1);
        run_to(9);
        tick(1'b1, 1'b1, 8'hAA, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        idle(24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
